// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the parametrised data-cache lookup controller.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    FLUSH
  } state_t;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Index width that never collapses to zero for single-entry dimensions.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [31:0] addr_word(input logic [31:0] addr, input int unsigned line_words);
    return (addr >> 2) & (line_words - 1);
  endfunction

  function automatic logic [31:0] addr_set(input logic [31:0] addr, input int unsigned sets,
                                           input int unsigned line_words);
    return (addr >> (2 + $clog2(line_words))) & (sets - 1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned sets,
                                           input int unsigned line_words);
    return addr >> (2 + $clog2(line_words) + $clog2(sets));
  endfunction

endpackage

// File: rtl/dcache_victim_sel.sv
// Per-set round-robin replacement pointers; an invalid way always wins, lowest index first.
module dcache_victim_sel
  import dcache_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [idx_w(SETS)-1:0]   set_idx,
  input  logic [WAYS-1:0]          valid_bits,
  input  logic                     advance,
  output logic [idx_w(WAYS)-1:0]   victim_way
);

  localparam int WAY_W = idx_w(WAYS);

  logic [WAY_W-1:0] rr_q [SETS];
  logic             found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (advance) begin
      rr_q[set_idx] <= (rr_q[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[set_idx] + WAY_W'(1);
    end
  end

  always_comb begin
    victim_way = rr_q[set_idx];
    found      = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!found && !valid_bits[w]) begin
        victim_way = WAY_W'(w);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_lookup.sv
// N-way set-associative data-cache lookup/hit controller between the AHB-lite slave port
// and the refill/write-back engine.
module dcache_lookup
  import dcache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 20
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        hsel,
  input  logic [1:0]                  htrans,
  input  logic                        hwrite,
  input  logic [ADDR_W-1:0]           haddr,
  input  logic [31:0]                 hwdata,
  output logic                        hready_out,
  output logic [31:0]                 hrdata,
  output logic                        miss_req,
  output logic [ADDR_W-1:0]           miss_addr,
  output logic [idx_w(WAYS)-1:0]      miss_way,
  output logic                        miss_wb,
  output logic [ADDR_W-1:0]           miss_wb_addr,
  output logic [32*LINE_WORDS-1:0]    miss_wb_data,
  input  logic                        miss_ack,
  input  logic                        refill_valid,
  input  logic [32*LINE_WORDS-1:0]    refill_data,
  input  logic                        flush_req,
  output logic                        flush_done,
  output state_t                      dbg_state
);

  localparam int WAY_W  = idx_w(WAYS);
  localparam int SET_W  = idx_w(SETS);
  localparam int WORD_W = idx_w(LINE_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int TAG_W  = ADDR_W - $clog2(SETS) - $clog2(LINE_WORDS) - 2;
  localparam int LINE_W = 32 * LINE_WORDS;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               write_q;
  logic [SET_W-1:0]   flush_set_q;
  logic               flush_done_q;
  logic               victim_valid_q;

  logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
  logic [LINE_W-1:0]  data_mem [WAYS][SETS];
  logic [WAYS-1:0]    valid_q  [SETS];
  logic [WAYS-1:0]    dirty_q  [SETS];

  logic [TAG_W-1:0]   lk_tag;
  logic [SET_W-1:0]   lk_set;
  logic [WORD_W-1:0]  lk_word;
  logic               hit;
  logic [WAY_W-1:0]   hit_way;
  logic [LINE_W-1:0]  hit_line;
  logic               lookup, accept, wr_hit, refill_fire;
  logic [WAY_W-1:0]   victim_way;

  assign lk_tag  = TAG_W'(addr_tag(32'(addr_q), SETS, LINE_WORDS));
  assign lk_set  = SET_W'(addr_set(32'(addr_q), SETS, LINE_WORDS));
  assign lk_word = WORD_W'(addr_word(32'(addr_q), LINE_WORDS));

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && tag_mem[w][lk_set] == lk_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  assign hit_line    = data_mem[hit_way][lk_set];
  assign lookup      = (state_q == LOOKUP);
  assign hready_out  = (state_q == IDLE) || (lookup && hit);
  assign accept      = hsel && (htrans == HTRANS_NONSEQ) && hready_out;
  assign hrdata      = (lookup && hit) ? hit_line[32*lk_word +: 32] : 32'h0;
  assign wr_hit      = lookup && hit && write_q;
  assign refill_fire = (state_q == REFILL) && refill_valid;

  // Refill engine handshake: miss_req and all miss_* fields are held stable from the cycle
  // after a lookup misses until the cycle miss_ack is sampled high; the line then arrives as a
  // single refill_valid pulse. Acks and refills seen in any other state are ignored.
  assign miss_req   = (state_q == MISS_REQ);
  assign flush_done = flush_done_q;
  assign dbg_state  = state_q;

  dcache_victim_sel #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_victim_sel (
    .clk        (clk),
    .reset_n    (reset_n),
    .set_idx    (lk_set),
    .valid_bits (valid_q[lk_set]),
    .advance    (refill_fire && victim_valid_q),
    .victim_way (victim_way)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = LOOKUP;
                else if (flush_req) state_d = FLUSH;
      LOOKUP:   if (!hit) state_d = MISS_REQ;
                else if (!accept) state_d = IDLE;
      MISS_REQ: if (miss_ack) state_d = REFILL;
      REFILL:   if (refill_valid) state_d = LOOKUP;
      FLUSH:    if (flush_set_q == SET_W'(SETS - 1)) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      write_q        <= 1'b0;
      flush_set_q    <= '0;
      flush_done_q   <= 1'b0;
      victim_valid_q <= 1'b0;
      miss_addr      <= '0;
      miss_way       <= '0;
      miss_wb        <= 1'b0;
      miss_wb_addr   <= '0;
      miss_wb_data   <= '0;
    end else begin
      state_q      <= state_d;
      flush_done_q <= (state_q == FLUSH) && (flush_set_q == SET_W'(SETS - 1));
      if (accept) begin
        addr_q  <= haddr;
        write_q <= hwrite;
      end
      if (state_q == FLUSH) flush_set_q <= flush_set_q + SET_W'(1);
      if (lookup && !hit) begin
        miss_addr      <= {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
        miss_way       <= victim_way;
        victim_valid_q <= valid_q[lk_set][victim_way];
        miss_wb        <= valid_q[lk_set][victim_way] && dirty_q[lk_set][victim_way];
        miss_wb_addr   <= {tag_mem[victim_way][lk_set], lk_set, OFF_W'(0)};
        miss_wb_data   <= data_mem[victim_way][lk_set];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else if (state_q == FLUSH) begin
      valid_q[flush_set_q] <= '0;
      dirty_q[flush_set_q] <= '0;
    end else if (refill_fire) begin
      valid_q[lk_set][miss_way] <= 1'b1;
      dirty_q[lk_set][miss_way] <= 1'b0;
    end else if (wr_hit) begin
      dirty_q[lk_set][hit_way] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (refill_fire) begin
      data_mem[miss_way][lk_set] <= refill_data;
      tag_mem[miss_way][lk_set]  <= lk_tag;
    end else if (wr_hit) begin
      data_mem[hit_way][lk_set][32*lk_word +: 32] <= hwdata;
    end
  end

endmodule

// File: tb/tb_dcache_lookup.sv
// Bench for dcache_lookup: directed vectors and corner sequences, then random traffic checked
// against a flat-memory model backed by a bench-side refill/write-back engine.
module tb_dcache_lookup;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          hsel, hwrite;
  logic [1:0]    htrans;
  logic [19:0]   haddr;
  logic [31:0]   hwdata;
  logic          hready_out;
  logic [31:0]   hrdata;
  logic          miss_req, miss_wb, miss_ack, refill_valid, flush_req, flush_done;
  logic [19:0]   miss_addr, miss_wb_addr;
  logic [1:0]    miss_way;
  logic [127:0]  miss_wb_data, refill_data;
  dcache_pkg::state_t dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_lookup dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hsel         (hsel),
    .htrans       (htrans),
    .hwrite       (hwrite),
    .haddr        (haddr),
    .hwdata       (hwdata),
    .hready_out   (hready_out),
    .hrdata       (hrdata),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .miss_way     (miss_way),
    .miss_wb      (miss_wb),
    .miss_wb_addr (miss_wb_addr),
    .miss_wb_data (miss_wb_data),
    .miss_ack     (miss_ack),
    .refill_valid (refill_valid),
    .refill_data  (refill_data),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- memory models ----------------
  logic [31:0] bmem    [logic [19:0]];
  logic [31:0] ref_mem [logic [19:0]];

  function automatic logic [31:0] dflt(input logic [19:0] a);
    return 32'hC0DE_0000 ^ {12'd0, a};
  endfunction

  function automatic logic [31:0] bget(input logic [19:0] a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rget(input logic [19:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- refill / write-back engine ----------------
  logic          resp_en;
  int            ack_delay, refill_delay, miss_cnt = 0;
  logic [19:0]   cap_addr, cap_wb_addr;
  logic [1:0]    cap_way;
  logic          cap_wb;
  logic [127:0]  cap_wb_data;

  initial begin
    miss_ack = 1'b0; refill_valid = 1'b0; refill_data = '0;
    forever begin
      @(negedge clk);
      if (resp_en && miss_req) begin
        cap_addr = miss_addr; cap_way = miss_way; cap_wb = miss_wb;
        cap_wb_addr = miss_wb_addr; cap_wb_data = miss_wb_data;
        miss_cnt++;
        if (miss_wb)
          for (int i = 0; i < 4; i++) bmem[miss_wb_addr + 20'(4*i)] = miss_wb_data[32*i +: 32];
        repeat (ack_delay) @(negedge clk);
        chk("miss_stable", 128'({miss_req, miss_addr, miss_way, miss_wb, miss_wb_addr}),
            128'({1'b1, cap_addr, cap_way, cap_wb, cap_wb_addr}));
        miss_ack = 1'b1; @(negedge clk); miss_ack = 1'b0;
        repeat (refill_delay) @(negedge clk);
        for (int i = 0; i < 4; i++) refill_data[32*i +: 32] = bget(cap_addr + 20'(4*i));
        refill_valid = 1'b1; @(negedge clk); refill_valid = 1'b0;
      end
    end
  end

  // ---------------- driver ----------------
  // Called just after a rising edge with the DUT idle; returns just after the completing edge.
  task automatic xfer(input logic wr, input logic [19:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int waits);
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = a;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wd;
    waits = 0;
    forever begin
      @(negedge clk);
      if (hready_out) break;
      waits++;
      if (waits > 300) begin
        errors++; checks++;
        $display("FAIL xfer_timeout: addr %0h still waiting after %0d cycles", a, waits);
        summary();
        $finish;
      end
    end
    rd = hrdata;
    @(posedge clk); #1;
  endtask

  initial begin
    #5ms;
    errors++; checks++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $finish;
  end

  typedef struct {
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t          tbl [4];
  logic [31:0]   rd;
  int            w, m0, n;
  logic [19:0]   fill_a [3];

  initial begin
    tbl[0] = '{1'b0, 20'h0014C, 32'h0, 32'h4};
    tbl[1] = '{1'b1, 20'h00144, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{1'b0, 20'h00144, 32'h0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 20'h00140, 32'h0, 32'h1};
    fill_a = '{20'h00240, 20'h00340, 20'h00440};

    reset_n = 1'b0; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hwdata = '0;
    flush_req = 1'b0; resp_en = 1'b1; ack_delay = 2; refill_delay = 1;
    repeat (3) @(posedge clk); #1;
    chk("rst_hready", 128'(hready_out), 128'(1'b1));
    chk("rst_outs", 128'({hrdata, miss_req, miss_wb, flush_done}), 128'(0));
    chk("rst_miss_bus", 128'({miss_addr, miss_way, miss_wb_addr}), 128'(0));
    chk("rst_wb_data", miss_wb_data, 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(dcache_pkg::IDLE));
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // cold miss and refill
    for (int i = 0; i < 4; i++) bmem[20'h00140 + 20'(4*i)] = 32'(i + 1);
    m0 = miss_cnt;
    xfer(1'b0, 20'h00148, 32'h0, rd, w);
    chk("cold_rd", 128'(rd), 128'(32'h3));
    chk("cold_waited", 128'(w >= 3), 128'(1'b1));
    chk("cold_one_miss", 128'(miss_cnt), 128'(m0 + 1));
    chk("cold_miss_addr", 128'(cap_addr), 128'(20'h00140));
    chk("cold_wb_way", 128'({cap_wb, cap_way}), 128'(0));

    // back-to-back zero-wait hits
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 20'h00140;
    @(posedge clk); #1; haddr = 20'h00144;
    @(negedge clk);
    chk("b2b_rdy0", 128'(hready_out), 128'(1'b1));
    chk("b2b_rd0", 128'(hrdata), 128'(32'h1));
    @(posedge clk); #1; hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    chk("b2b_rdy1", 128'(hready_out), 128'(1'b1));
    chk("b2b_rd1", 128'(hrdata), 128'(32'h2));
    @(posedge clk); #1;

    // hit vectors
    for (int i = 0; i < 4; i++) begin
      xfer(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, w);
      if (!tbl[i].wr) chk($sformatf("vec%0d_rd", i), 128'(rd), 128'(tbl[i].exp_rd));
      chk($sformatf("vec%0d_waits", i), 128'(w), 128'(0));
    end

    // fill set 4 through invalid ways, then evict by round robin
    for (int i = 0; i < 3; i++) begin
      m0 = miss_cnt;
      xfer(1'b0, fill_a[i], 32'h0, rd, w);
      chk($sformatf("fill%0d_rd", i), 128'(rd), 128'(dflt(fill_a[i])));
      chk($sformatf("fill%0d_miss", i), 128'(miss_cnt), 128'(m0 + 1));
      chk($sformatf("fill%0d_way", i), 128'(cap_way), 128'(i + 1));
    end
    xfer(1'b0, 20'h00540, 32'h0, rd, w);
    chk("evict5_rd", 128'(rd), 128'(dflt(20'h00540)));
    chk("evict5_way_wb", 128'({cap_way, cap_wb}), 128'({2'd0, 1'b1}));
    chk("evict5_wb_addr", 128'(cap_wb_addr), 128'(20'h00140));
    chk("evict5_wb_data", cap_wb_data, 128'h00000004_00000003_DEADBEEF_00000001);
    xfer(1'b0, 20'h00640, 32'h0, rd, w);
    chk("evict6_way_wb", 128'({cap_way, cap_wb}), 128'({2'd1, 1'b0}));
    chk("evict6_wb_addr", 128'(cap_wb_addr), 128'(20'h00240));
    xfer(1'b0, 20'h00144, 32'h0, rd, w);
    chk("wb_reload_rd", 128'(rd), 128'(32'hDEADBEEF));
    chk("wb_reload_way", 128'(cap_way), 128'(2'd2));

    // flush
    flush_req = 1'b1;
    @(posedge clk); #1; flush_req = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (hready_out || n > 100) break;
      n++;
    end
    chk("flush_cycles", 128'(n), 128'(16));
    chk("flush_done_pulse", 128'(flush_done), 128'(1'b1));
    @(posedge clk); #1;
    chk("flush_done_drop", 128'(flush_done), 128'(1'b0));
    m0 = miss_cnt;
    xfer(1'b0, 20'h00144, 32'h0, rd, w);
    chk("post_flush_miss", 128'(miss_cnt), 128'(m0 + 1));
    chk("post_flush_rd", 128'(rd), 128'(32'hDEADBEEF));

    // reset while a miss is pending
    resp_en = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 20'h00248;
    @(posedge clk); #1; hsel = 1'b0; htrans = 2'b00;
    n = 0;
    while (!miss_req && n < 20) begin @(negedge clk); n++; end
    chk("rst_mid_reached", 128'(miss_req), 128'(1'b1));
    @(negedge clk); reset_n = 1'b0; #1;
    chk("rst_mid_req", 128'(miss_req), 128'(1'b0));
    chk("rst_mid_hready", 128'(hready_out), 128'(1'b1));
    chk("rst_mid_bus", 128'({miss_addr, miss_wb}), 128'(0));
    #2 reset_n = 1'b1;
    @(posedge clk); #1; resp_en = 1'b1;
    m0 = miss_cnt;
    xfer(1'b0, 20'h00144, 32'h0, rd, w);
    chk("rst_mid_refetch_miss", 128'(miss_cnt), 128'(m0 + 1));
    chk("rst_mid_refetch_rd", 128'(rd), 128'(32'hDEADBEEF));

    // random traffic against a flat memory model
    reset_n = 1'b0; #2 reset_n = 1'b1;
    bmem.delete(); ref_mem.delete();
    @(posedge clk); #1;
    for (int k = 0; k < 400; k++) begin
      logic [19:0] a;
      logic [31:0] wd;
      logic        wr;
      a  = {12'($urandom_range(1, 6)), 4'($urandom_range(3, 5)), 2'($urandom_range(0, 3)), 2'b00};
      wr = ($urandom_range(0, 9) < 3);
      wd = $urandom;
      ack_delay = $urandom_range(0, 3); refill_delay = $urandom_range(0, 3);
      xfer(wr, a, wd, rd, w);
      if (wr) ref_mem[a] = wd;
      else chk($sformatf("rand%0d_rd", k), 128'(rd), 128'(rget(a)));
      if ($urandom_range(0, 3) == 0) begin
        xfer(1'b0, a, 32'h0, rd, w);
        chk($sformatf("rand%0d_rehit_rd", k), 128'(rd), 128'(rget(a)));
        chk($sformatf("rand%0d_rehit_waits", k), 128'(w), 128'(0));
      end
    end

    summary();
    $finish;
  end

endmodule
